// File: rtl/tristate_buffer.sv
// tristate_buffer
//   Parameterised bank of tristate output drivers with clocked side logic:
//   a registered drive-status flag, a saturating drive-cycle counter and
//   sticky per-bit contention flags against an external driver.
//
//   The data path (in/en -> out) is purely combinational. Reset releases
//   every line to high-Z at once, without waiting for a clock.
//
//   Optional feature: define BUS_KEEPER_EN to add a per-bit keeper register.
//   The keeper holds the last value driven on each bit and drives it onto a
//   disabled line instead of high-Z (weak bus-hold emulation). During reset
//   the lines are still released to high-Z.
module tristate_buffer #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] ext_drive,
    input  logic             clr,
    output tri   [WIDTH-1:0] out,
    output logic             drive_active,
    output logic [CNT_W-1:0] drive_cnt,
    output logic [WIDTH-1:0] contention
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] BITS_ZERO = {WIDTH{1'b0}};

    // ------------------------------------------------------------------
    // Status registers
    // ------------------------------------------------------------------
    logic             drive_active_r;
    logic [CNT_W-1:0] drive_cnt_r;
    logic [WIDTH-1:0] contention_r;

    logic             any_en_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [WIDTH-1:0] cont_next_s;

    // Per-bit line control: drive_en_s selects driving vs. release,
    // drive_val_s is the value placed on the line when driving.
    logic [WIDTH-1:0] drive_en_s;
    logic [WIDTH-1:0] drive_val_s;

    assign any_en_s = |en;

    // Next drive-cycle count: clear wins, otherwise saturating increment.
    always_comb begin
        cnt_next_s = drive_cnt_r;
        if (clr) begin
            cnt_next_s = CNT_ZERO;
        end else if (any_en_s && (drive_cnt_r != CNT_MAX)) begin
            cnt_next_s = drive_cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = drive_cnt_r;
        end
    end

    // Next contention flags: sticky set on simultaneous drive, clear wins.
    always_comb begin
        cont_next_s = contention_r;
        if (clr) begin
            cont_next_s = BITS_ZERO;
        end else begin
            cont_next_s = contention_r | (en & ext_drive);
        end
    end

    // Status register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_active_r <= 1'b0;
            drive_cnt_r    <= CNT_ZERO;
            contention_r   <= BITS_ZERO;
        end else begin
            drive_active_r <= any_en_s;
            drive_cnt_r    <= cnt_next_s;
            contention_r   <= cont_next_s;
        end
    end

    assign drive_active = drive_active_r;
    assign drive_cnt    = drive_cnt_r;
    assign contention   = contention_r;

`ifdef BUS_KEEPER_EN
    // ------------------------------------------------------------------
    // Bus keeper: remembers the last driven value of each bit
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] keeper_r;
    logic [WIDTH-1:0] keeper_next_s;

    // Keeper follows in[i] while bit i is enabled, otherwise holds.
    always_comb begin
        keeper_next_s = (en & in) | (~en & keeper_r);
    end

    // Keeper storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keeper_r <= BITS_ZERO;
        end else begin
            keeper_r <= keeper_next_s;
        end
    end

    // Out of reset every line is driven: live data when enabled, the kept
    // value otherwise. An unknown enable propagates through the mux.
    assign drive_en_s  = {WIDTH{rst_n}};
    assign drive_val_s = (en & in) | (~en & keeper_r);
`else
    // A line is driven only when enabled and out of reset; an unknown
    // enable leaves the line unknown rather than guessing.
    assign drive_en_s  = en & {WIDTH{rst_n}};
    assign drive_val_s = in;
`endif

    // ------------------------------------------------------------------
    // Tristate line drivers (zero latency, no clock involvement)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_drv
        assign out[gi] = drive_en_s[gi] ? drive_val_s[gi] : 1'bz;
    end

endmodule

// File: tb/tb_tristate_buffer.sv
// Scoreboard bench for tristate_buffer (WIDTH=8, CNT_W=3).
// Two identical instances drive nets with opposite pull types so that a
// released (high-Z) line is distinguishable from a driven 0 or 1.
module tb_tristate_buffer;

    localparam int W    = 8;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_v;
    logic [W-1:0]  en_v;
    logic [W-1:0]  ext_v;
    logic          clr_v;

    tri1 [W-1:0]   out_pu;
    tri0 [W-1:0]   out_pd;
    logic          act_pu, act_pd;
    logic [CW-1:0] cnt_pu, cnt_pd;
    logic [W-1:0]  cont_pu, cont_pd;

    tristate_buffer #(.WIDTH(W), .CNT_W(CW)) dut_pu (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en_v), .ext_drive(ext_v),
        .clr(clr_v), .out(out_pu), .drive_active(act_pu),
        .drive_cnt(cnt_pu), .contention(cont_pu)
    );

    tristate_buffer #(.WIDTH(W), .CNT_W(CW)) dut_pd (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en_v), .ext_drive(ext_v),
        .clr(clr_v), .out(out_pd), .drive_active(act_pd),
        .drive_cnt(cnt_pd), .contention(cont_pd)
    );

    always #5 clk = ~clk;

    // Expected response for one observation point
    typedef struct {
        logic [W-1:0] drv;
        logic [W-1:0] val;
        logic         act;
        int           cnt;
        logic [W-1:0] cont;
    } exp_t;

    exp_t q[$];
    event probe;
    bit   done = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    bit       m_act;
    int       m_cnt;
    bit [W-1:0] m_cont;
    bit [W-1:0] m_keep;

    function automatic void model_reset();
        m_act  = 1'b0;
        m_cnt  = 0;
        m_cont = '0;
        m_keep = '0;
    endfunction

    // Effect of one rising clock with the current inputs
    function automatic void model_edge();
        if (rst_n) begin
            m_act = (en_v != 0);
            if (clr_v) begin
                m_cnt  = 0;
                m_cont = '0;
            end else begin
                if (en_v != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
                m_cont = m_cont | (en_v & ext_v);
            end
            for (int b = 0; b < W; b++) if (en_v[b]) m_keep[b] = in_v[b];
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        if (!rst_n) begin
            e.drv = '0;
            e.val = '0;
        end else begin
`ifdef BUS_KEEPER_EN
            e.drv = '1;
            for (int b = 0; b < W; b++) e.val[b] = en_v[b] ? in_v[b] : m_keep[b];
`else
            e.drv = en_v;
            e.val = in_v;
`endif
        end
        e.act  = m_act;
        e.cnt  = m_cnt;
        e.cont = m_cont;
        q.push_back(e);
    endfunction

    // Apply one set of inputs, have the monitor check, then take a clock
    task automatic step(input logic [W-1:0] i_in, input logic [W-1:0] i_en,
                        input logic [W-1:0] i_ext, input logic i_clr);
        in_v  = i_in;
        en_v  = i_en;
        ext_v = i_ext;
        clr_v = i_clr;
        push_exp();
        #3;
        -> probe;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every queued expectation when the DUT is sampled
    initial begin
        exp_t e;
        logic [W-1:0] obs_drv;
        forever begin
            @(probe);
            while (q.size() > 0) begin
                e = q.pop_front();
                obs_drv = ~(out_pu & ~out_pd);
                chk("out{drv,val}", {16'h0, obs_drv, out_pu & obs_drv},
                    {16'h0, e.drv, e.val & e.drv});
                chk("drive_active", {31'h0, act_pu}, {31'h0, e.act});
                chk("drive_cnt", 32'(cnt_pu), 32'(e.cnt));
                chk("contention", {24'h0, cont_pu}, {24'h0, e.cont});
                chk("pd_instance_regs", {20'h0, act_pd, cnt_pd, cont_pd},
                    {20'h0, e.act, 3'(e.cnt), e.cont});
            end
            if (done) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Driver
    initial begin
        rst_n = 1'b0;
        in_v  = '0;
        en_v  = 8'hFF;
        ext_v = '0;
        clr_v = 1'b0;
        model_reset();
        #2;
        push_exp();            // reset state: lines released, regs zero
        -> probe;
        #1;
        en_v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Basic drive / release patterns
        step(8'h00, 8'h00, 8'h00, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 1'b0);
        step(8'h00, 8'hFF, 8'h00, 1'b0);
        step(8'hFF, 8'hFF, 8'h00, 1'b0);
        // Partial enable, clr coinciding with a count event
        step(8'hA5, 8'h0F, 8'h00, 1'b1);
        // Five enabled clocks, three idle
        for (int k = 0; k < 5; k++) step(8'(k * 37), 8'h81, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) step(8'h5A, 8'h00, 8'hFF, 1'b0);
        // Ten more enabled clocks to saturate the counter
        for (int k = 0; k < 10; k++) step(8'hC3, 8'h10, 8'h00, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0);
        // Contention on bit 2, persistence, clear, clear-vs-new-event
        step(8'h00, 8'h04, 8'h04, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0);
        step(8'h00, 8'h00, 8'h04, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b1);
        step(8'h00, 8'h04, 8'h04, 1'b1);
        step(8'h00, 8'h00, 8'h00, 1'b0);
        // Keeper pattern
        step(8'h3C, 8'hFF, 8'h00, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset between clock edges while driving
        in_v  = 8'hFF;
        en_v  = 8'hFF;
        ext_v = 8'hFF;
        clr_v = 1'b0;
        push_exp();
        #3;
        -> probe;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        -> probe;
        #1;
        rst_n = 1'b1;
        #1;
        push_exp();
        -> probe;
        @(posedge clk);
        model_edge();
        #1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] r_in, r_en, r_ext;
            logic r_clr;
            r_in  = 8'($urandom);
            r_en  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            r_ext = 8'($urandom);
            r_clr = ($urandom_range(0, 15) == 0);
            step(r_in, r_en, r_ext, r_clr);
        end

        done = 1'b1;
        -> probe;
    end

endmodule
